// File: rtl/iob_rom_stream_pkg.sv
// Shared constants and state encoding for the ROM streaming engine.
package iob_rom_stream_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/iob_rom_stream_fifo.sv
// Two-entry fall-through buffer: an incoming word is presented on the
// output in the same cycle when the buffer is empty, and is stored only
// if the consumer does not take it immediately.
module iob_rom_stream_fifo
    import iob_rom_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_W-1:0]     mem [FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [FIFO_CNT_W-1:0] cnt_q;
    logic                  empty;
    logic                  bypass;
    logic                  push;
    logic                  pop;

    assign empty     = (cnt_q == '0);
    assign in_ready  = (cnt_q < FIFO_CNT_W'(FIFO_DEPTH));
    assign bypass    = empty && in_valid && out_ready;
    assign push      = in_valid && in_ready && !bypass;
    assign pop       = !empty && out_ready;
    assign out_valid = !empty || in_valid;
    assign count     = cnt_q;

    // Head of buffer when occupied, otherwise the arriving word, otherwise 0.
    always_comb begin
        out_data = '0;
        if (!empty) begin
            out_data = mem[rd_ptr];
        end else if (in_valid) begin
            out_data = in_data;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + FIFO_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - FIFO_CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/iob_rom_stream.sv
// Streams len consecutive ROM words starting at base (address wraps) onto a
// valid/ready interface. Optional feature macro: IOB_ROM_STREAM_LOOP_EN adds
// loop_i, which restarts the pass at the latched base/len instead of finishing.
module iob_rom_stream
    import iob_rom_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
`ifdef IOB_ROM_STREAM_LOOP_EN
    input  logic              loop_i,
`endif
    output logic              rom_r_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_r_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned OCC_W = FIFO_CNT_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    rd_left_q, rd_left_d;
    logic [LEN_W-1:0]    xfer_left_q, xfer_left_d;
    logic                in_flight_q;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                  loop_en;
    logic                  fifo_in_ready;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0]      occ;
    logic                  issue;
    logic                  xfer;

`ifdef IOB_ROM_STREAM_LOOP_EN
    assign loop_en = loop_i;
`else
    assign loop_en = 1'b0;
`endif

    // Buffered words plus the read still in flight bound how far ahead we may read.
    assign occ   = OCC_W'(fifo_count) + OCC_W'(in_flight_q);
    assign issue = (state_q == READ) && fifo_in_ready && (occ < OCC_W'(FIFO_DEPTH));
    assign xfer  = valid_o && ready_i;

    assign rom_r_en_o = issue;
    assign rom_addr_o = issue ? addr_q : '0;
    assign last_o     = valid_o && (xfer_left_q == LEN_W'(1));
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    iob_rom_stream_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (arst_n_i),
        .in_valid  (in_flight_q),
        .in_data   (rom_r_data_i),
        .in_ready  (fifo_in_ready),
        .out_valid (valid_o),
        .out_data  (data_o),
        .out_ready (ready_i),
        .count     (fifo_count)
    );

    // State register and counters.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            rd_left_q   <= '0;
            xfer_left_q <= '0;
            in_flight_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            len_q       <= len_d;
            rd_left_q   <= rd_left_d;
            xfer_left_q <= xfer_left_d;
            in_flight_q <= issue;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state: accept start, walk read addresses, finish or loop on last transfer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        base_d      = base_q;
        len_d       = len_q;
        rd_left_d   = rd_left_q;
        xfer_left_d = xfer_left_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d     = READ;
                        base_d      = base_addr_i;
                        len_d       = len_i;
                        addr_d      = base_addr_i;
                        rd_left_d   = len_i;
                        xfer_left_d = len_i;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - LEN_W'(1);
                    if (rd_left_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // All reads are already issued when the final word transfers.
        if (xfer) begin
            xfer_left_d = xfer_left_q - LEN_W'(1);
            if (xfer_left_q == LEN_W'(1)) begin
                if (loop_en) begin
                    state_d     = READ;
                    addr_d      = base_q;
                    rd_left_d   = len_q;
                    xfer_left_d = len_q;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/iob_rom_stream.md
IOB_ROM_STREAM -- requirements
Module: iob_rom_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ROM word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, ROM address width in bits.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  start request, sampled in IDLE only.
REQ-006 SHALL have port base_addr_i  input  ADDR_W  first ROM address, latched on accepted start.
REQ-007 SHALL have port len_i  input  ADDR_W+1  word count (0..2^ADDR_W), latched on accepted start.
REQ-008 SHALL have port rom_r_en_o  output  1  ROM read enable.
REQ-009 SHALL have port rom_addr_o  output  ADDR_W  ROM read address.
REQ-010 SHALL have port rom_r_data_i  input  DATA_W  ROM read data, valid exactly 1 cycle after rom_r_en_o.
REQ-011 SHALL have port data_o  output  DATA_W  stream data.
REQ-012 SHALL have port valid_o  output  1  stream data valid.
REQ-013 SHALL have port ready_i  input  1  downstream ready; transfer when valid_o and ready_i both high.
REQ-014 SHALL have port last_o  output  1  high with final word of a pass.
REQ-015 SHALL have port busy_o  output  1  high from accepted start until done.
REQ-016 SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL use FSM states IDLE, READ, DRAIN; IDLE->READ on start_i with len_i>0; READ->DRAIN after last read issued; DRAIN->IDLE on last-word transfer.
REQ-018 SHALL ignore start_i while busy_o is high.
REQ-019 SHALL, for start with len_i=0, stay in IDLE, produce no reads/valid, pulse done_o the cycle after start.
REQ-020 SHALL issue k-th read (k=0..len-1) at address (base+k) mod 2^ADDR_W, wrapping 2^ADDR_W-1 -> 0.
REQ-021 SHALL buffer returned data in a 2-entry FIFO; read issued only if occupancy plus in-flight read < 2.
REQ-022 SHALL, with start accepted at edge t and ready_i high, assert rom_r_en_o in cycle t+1 and valid_o in cycle t+2.
REQ-023 SHALL sustain one word per cycle while ready_i stays high.
REQ-024 SHALL hold data_o/valid_o/last_o stable while valid_o high and ready_i low; no word lost or duplicated.
REQ-025 SHALL drive done_o high, busy_o low, in the cycle after last-word transfer.
REQ-026 SHALL drive rom_addr_o to 0 when rom_r_en_o is low.

Reset
REQ-027 SHALL, on arst_n_i low, immediately force IDLE, empty FIFO, cancel in-flight read, all outputs 0.
REQ-028 SHALL, after reset release mid-stream, require a new start_i; no residual words emitted.

Configuration
REQ-029 SHALL, with IOB_ROM_STREAM_LOOP_EN defined, add port loop_i input 1; if high at last-word transfer, restart at latched base with same len, last_o asserted each pass, no done_o/busy_o drop.
REQ-030 SHALL, without IOB_ROM_STREAM_LOOP_EN, omit loop_i; behaviour exactly as REQ-017..REQ-028.

Structure
REQ-031 SHALL place FSM state encoding and FIFO depth constant (2) in shared package iob_rom_stream_pkg.
REQ-032 SHALL implement the buffer as sub-module iob_rom_stream_fifo (2-entry, valid/ready, async active-low reset).

Verification (ROM rom[i]=i+32, DATA_W=8, ADDR_W=4, 1-cycle ROM)
REQ-033 SHALL test base=0 len=16 ready=1 -> 32..47 on consecutive cycles, last_o with 47, one done_o.
REQ-034 SHALL test base=14 len=4 -> 46,47,32,33 (wrap), last_o with 33.
REQ-035 SHALL test base=0 len=16, ready_i high 1 cycle in 3 -> 32..47 in order, no gaps/dups, never >2 buffered.
REQ-036 SHALL test len=0 -> no valid_o, no rom_r_en_o, done_o one cycle after start.
REQ-037 SHALL test reset after 5 words of base=0 len=16 -> outputs 0 at once; then base=3 len=2 -> 35,36 only.
REQ-038 SHALL test (LOOP_EN) base=0 len=3 loop_i=1 for 2 passes then 0 -> 32,33,34,32,33,34, last_o twice, done_o once.
